// File: rtl/pulse_seg_pkg.sv
// Purpose: shared seven-segment constants and the digit-glyph lookup.
// Latency: purely combinational helpers, no state.
// Backpressure: none; values are consumed directly by the display decoders.
// Optional feature macro: PULSE_SEG_HEX_EN (glyphs for codes 10-15; blank otherwise).
// Segment order in every 7-bit glyph is {g,f,e,d,c,b,a}, active-low.
package pulse_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  function automatic logic [6:0] seg_glyph(input logic [3:0] code);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (code)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
`ifdef PULSE_SEG_HEX_EN
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
`else
      // Decimal-only build: non-BCD codes show nothing rather than garbage.
      default: seg = SEG_BLANK;
`endif
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purpose: decode one 4-bit digit code into an active-low seven-segment glyph.
// Latency: combinational, settles in the same cycle as code changes.
// Backpressure: none.
// Ports: code [3:0] in, seg [6:0] out as {g,f,e,d,c,b,a}, active-low.
// Optional feature macro: PULSE_SEG_HEX_EN (via pulse_seg_pkg::seg_glyph).
module hex_to_seg7
  import pulse_seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = seg_glyph(code);

endmodule

// File: rtl/pulse_seg_display.sv
// Purpose: rising-edge pulse generator plus multi-digit seven-segment decode with sign slot.
// Latency: pulse_out one clock after the first sampled 1; displays combinational (same cycle).
// Backpressure: none; free-running, every input change is reflected.
// Ports: clk, rst (async active-high), level_in -> pulse_out,
//        digits [4*NUM_DIGITS-1:0] + negative -> displays [7*NUM_DISPLAYS-1:0] (active-low).
// Optional feature macro: PULSE_SEG_HEX_EN (hex glyphs A-F on digit codes 10-15).
module pulse_seg_display
  import pulse_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_DISPLAYS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      level_in,
  output logic                      pulse_out,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic                      negative,
  output logic [7*NUM_DISPLAYS-1:0] displays
);

  if (NUM_DIGITS == 0 || NUM_DISPLAYS < NUM_DIGITS) begin : g_param_check
    $fatal(1, "pulse_seg_display: need NUM_DIGITS > 0 and NUM_DISPLAYS >= NUM_DIGITS");
  end

  logic lvl_q;
  logic pulse_q;

  // lvl_q resets high so a level already high at reset release is not
  // mistaken for a fresh edge; a real low sample is needed first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q   <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= level_in & ~lvl_q;
      lvl_q   <= level_in;
    end
  end

  assign pulse_out = pulse_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    hex_to_seg7 u_dec (
      .code (digits[4*i +: 4]),
      .seg  (displays[7*i +: 7])
    );
  end

  // The slot just above the digits carries the sign: {~negative, 6'h3F}.
  if (NUM_DISPLAYS > NUM_DIGITS) begin : g_sign
    assign displays[7*NUM_DIGITS +: 7] = negative ? SEG_MINUS : SEG_BLANK;
  end

  for (genvar j = NUM_DIGITS + 1; j < NUM_DISPLAYS; j++) begin : g_blank
    assign displays[7*j +: 7] = SEG_BLANK;
  end

endmodule

// File: tb/tb_pulse_seg_display.sv
// Purpose: scoreboard bench for pulse_seg_display with default parameters.
// Latency: expectations are tagged with the cycle in which they must appear.
// Backpressure: none; the monitor pops every entry due in the current cycle.
module tb_pulse_seg_display;

  localparam int ND = 4;
  localparam int NS = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          level_in = 1'b1;
  logic          negative = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic          pulse_out;
  logic [7*NS-1:0] displays;

  always #5 clk = ~clk;

  pulse_seg_display #(.NUM_DIGITS(ND), .NUM_DISPLAYS(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .level_in  (level_in),
    .pulse_out (pulse_out),
    .digits    (digits),
    .negative  (negative),
    .displays  (displays)
  );

  typedef struct {
    int          cyc;
    logic [41:0] val;
  } ent_t;

  ent_t        pq[$];
  ent_t        dq[$];
  logic [6:0]  glyph [16];
  logic        last_sample;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pulses_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each slot is its glyph, sign slot minus/blank, everything else blank.
  function automatic logic [41:0] model_disp(input logic [15:0] dg, input logic neg);
    logic [41:0] v;
    v = '1;
    for (int i = 0; i < ND; i++) v[7*i +: 7] = glyph[dg[4*i +: 4]];
    v[7*ND +: 7] = neg ? 7'h3F : 7'h7F;
    return v;
  endfunction

  // Monitor: compares every expectation due in this cycle, away from the clock edge.
  always @(negedge clk) begin
    ent_t e;
    if (pulse_out === 1'b1) pulses_seen++;
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      e = pq.pop_front();
      check("pulse_out", {41'b0, pulse_out}, e.val);
    end
    while (dq.size() > 0 && dq[0].cyc <= cyc) begin
      e = dq.pop_front();
      check("displays", displays, e.val);
    end
  end

  // A pulse is due the cycle after a sample of 1 that follows a sample of 0
  // (reset counts as having sampled 1).
  task automatic drive_cycle(input logic lvl, input logic [15:0] dg, input logic neg);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    level_in = lvl;
    digits   = dg;
    negative = neg;
    pq.push_back('{cyc + 1, {41'b0, lvl & ~last_sample}});
    last_sample = lvl;
    dq.push_back('{cyc, model_disp(dg, neg)});
  endtask

  task automatic do_reset(input int ncyc, input logic lvl);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    level_in = lvl;
    while (pq.size() > 0 && pq[pq.size()-1].cyc >= cyc) void'(pq.pop_back());
    pq.push_back('{cyc, 42'd0});
    last_sample = 1'b1;
    repeat (ncyc - 1) begin
      @(posedge clk);
      #1;
      pq.push_back('{cyc, 42'd0});
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    logic [41:0] exp_vec;
    logic [3:0]  code;

    glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
    glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
    glyph[8] = 7'h00; glyph[9] = 7'h10;
`ifdef PULSE_SEG_HEX_EN
    glyph[10] = 7'h08; glyph[11] = 7'h03; glyph[12] = 7'h46;
    glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
`else
    for (int k = 10; k < 16; k++) glyph[k] = 7'h7F;
`endif
    last_sample = 1'b1;

    // Reset with level high, then hold high: no pulse at all.
    do_reset(3, 1'b1);
    p0 = pulses_seen;
    repeat (10) drive_cycle(1'b1, 16'h1234, 1'b0);
    settle();
    check("no_pulse_after_reset", 42'(pulses_seen - p0), 42'd0);

    // 0,0 then 1 x5: exactly one pulse.
    p0 = pulses_seen;
    repeat (2) drive_cycle(1'b0, 16'h0000, 1'b0);
    repeat (5) drive_cycle(1'b1, 16'h0000, 1'b0);
    settle();
    check("single_pulse_count", 42'(pulses_seen - p0), 42'd1);

    // Back-to-back toggling 0,1,0,1: two pulses.
    p0 = pulses_seen;
    drive_cycle(1'b0, 16'h5555, 1'b1);
    drive_cycle(1'b1, 16'h5555, 1'b1);
    drive_cycle(1'b0, 16'h5555, 1'b1);
    drive_cycle(1'b1, 16'h5555, 1'b1);
    settle();
    check("toggle_pulse_count", 42'(pulses_seen - p0), 42'd2);

    // Fixed display pattern, checked directly as well.
    drive_cycle(1'b1, 16'h9876, 1'b1);
    #1;
    exp_vec = {7'h7F, 7'h3F, 7'h10, 7'h00, 7'h78, 7'h02};
    check("displays_9876_neg", displays, exp_vec);

    // Every code on digit 0.
    for (int c = 0; c < 16; c++) begin
      code = c[3:0];
      drive_cycle(1'b1, {12'h000, code}, 1'b0);
    end

    // Asynchronous reset while the pulse is high kills it before the next edge.
    drive_cycle(1'b0, 16'h0042, 1'b0);
    drive_cycle(1'b1, 16'h0042, 1'b0);
    @(posedge clk);
    #7;
    check("pulse_high_before_rst", {41'b0, pulse_out}, 42'd1);
    rst = 1'b1;
    #1;
    check("pulse_killed_by_rst", {41'b0, pulse_out}, 42'd0);
    last_sample = 1'b1;
    @(posedge clk);
    #1;
    pq.push_back('{cyc, 42'd0});

    // Randomized traffic with occasional resets.
    repeat (300) begin
      if ($urandom_range(0, 30) == 0)
        do_reset(2, 1'($urandom_range(0, 1)));
      else
        drive_cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    settle();
    check("scoreboard_drained", 42'(pq.size() + dq.size()), 42'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
